// File: rtl/spi_master_cfg_if.sv
// Request, serial-line and status bundle between the core logic
// and the configurable SPI master.
interface spi_master_cfg_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W:0]   _i_to_transmit;
   logic              _i_miso;
   logic [DATA_W+4:0] __output;

   modport master (
      input  _i_to_transmit,
      input  _i_miso,
      output __output
   );

   modport slave (
      output _i_to_transmit,
      output _i_miso,
      input  __output
   );
endinterface

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: word width, SCLK divider, CPOL/CPHA,
// bit order, chip select and MISO receive with a done strobe.
module spi_master_cfg #(
   parameter int DATA_W      = 8,
   parameter int HALF_PERIOD = 500,
   parameter int CPOL        = 1,
   parameter int CPHA        = 0,
   parameter int LSB_FIRST   = 1
) (
   input  logic             _i_clk,
   input  logic             _i_rst,
   spi_master_cfg_if.master bus
);
   localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic IDLE_LVL = (CPOL != 0);
   // SCLK level during phase A; phase B is always its inverse
   localparam logic LEAD_LVL = (CPHA != 0) ? !IDLE_LVL : IDLE_LVL;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t            state_q, state_d;
   logic              phase_q, phase_d;
   logic [HW-1:0]     hp_q, hp_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              cs_n_q, cs_n_d;
   logic              busy_q, busy_d;
   logic              rx_valid_q, rx_valid_d;

   logic              req_valid;
   logic [DATA_W-1:0] req_data;
   logic              hp_end;
   logic              last_bit;

   assign req_valid = bus._i_to_transmit[DATA_W];
   assign req_data  = bus._i_to_transmit[DATA_W-1:0];
   assign hp_end    = (hp_q == HW'(HALF_PERIOD - 1));
   assign last_bit  = (bit_q == BW'(DATA_W - 1));

   function automatic logic [BW-1:0] pos(input logic [BW-1:0] i);
      return (LSB_FIRST != 0) ? i : BW'(DATA_W - 1) - i;
   endfunction

   always_ff @(posedge _i_clk or posedge _i_rst) begin
      if (_i_rst) begin
         state_q    <= S_IDLE;
         phase_q    <= 1'b0;
         hp_q       <= '0;
         bit_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rx_data_q  <= '0;
         sclk_q     <= IDLE_LVL;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         hp_q       <= hp_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rx_data_q  <= rx_data_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (req_valid) state_d = S_SHIFT;
         S_SHIFT: if (hp_end && phase_q && last_bit) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      phase_d    = phase_q;
      hp_d       = hp_q;
      bit_d      = bit_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      rx_valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               tx_d    = req_data;
               rx_d    = '0;
               mosi_d  = req_data[pos('0)];
               sclk_d  = LEAD_LVL;
               phase_d = 1'b0;
               hp_d    = '0;
               bit_d   = '0;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_SHIFT: begin
            hp_d = hp_end ? '0 : hp_q + HW'(1);
            if (hp_end && !phase_q) begin
               phase_d          = 1'b1;
               sclk_d           = !LEAD_LVL;
               rx_d[pos(bit_q)] = bus._i_miso;
            end else if (hp_end && !last_bit) begin
               phase_d = 1'b0;
               sclk_d  = LEAD_LVL;
               bit_d   = bit_q + BW'(1);
               mosi_d  = tx_q[pos(bit_q + BW'(1))];
            end else if (hp_end) begin
               phase_d    = 1'b0;
               sclk_d     = IDLE_LVL;
               cs_n_d     = 1'b1;
               busy_d     = 1'b0;
               rx_data_d  = rx_q;
               rx_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.__output = {sclk_q, mosi_q, cs_n_q, busy_q,
                          rx_valid_q, rx_data_q};
endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg across several
// width, divider, mode and bit-order configurations.
module tb_spi_master_cfg;
   localparam int NI = 7;
   localparam int DW[NI]   = '{8, 16, 8, 8, 8, 8, 1};
   localparam int HP[NI]   = '{500, 4, 2, 2, 2, 2, 1};
   localparam int CPL[NI]  = '{1, 1, 0, 0, 1, 1, 1};
   localparam int CPH[NI]  = '{0, 0, 0, 1, 0, 1, 0};
   localparam int LSBF[NI] = '{1, 0, 1, 1, 0, 0, 1};

   logic        clk;
   logic        rst;
   logic [16:0] req  [NI];
   logic        miso [NI];
   logic [20:0] obus [NI];

   int n_tests = 0;
   int n_fail  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   spi_master_cfg_if #(.DATA_W(8)) if0();
   assign if0._i_to_transmit = {req[0][16], req[0][7:0]};
   assign if0._i_miso = miso[0];
   assign obus[0] = 21'(if0.__output);
   spi_master_cfg #(.DATA_W(8), .HALF_PERIOD(500), .CPOL(1),
                    .CPHA(0), .LSB_FIRST(1))
      u0 (._i_clk(clk), ._i_rst(rst), .bus(if0.master));

   spi_master_cfg_if #(.DATA_W(16)) if1();
   assign if1._i_to_transmit = req[1];
   assign if1._i_miso = miso[1];
   assign obus[1] = 21'(if1.__output);
   spi_master_cfg #(.DATA_W(16), .HALF_PERIOD(4), .CPOL(1),
                    .CPHA(0), .LSB_FIRST(0))
      u1 (._i_clk(clk), ._i_rst(rst), .bus(if1.master));

   for (genvar m = 0; m < 4; m++) begin : g_mode
      spi_master_cfg_if #(.DATA_W(8)) ifm();
      assign ifm._i_to_transmit = {req[2+m][16], req[2+m][7:0]};
      assign ifm._i_miso = miso[2+m];
      assign obus[2+m] = 21'(ifm.__output);
      spi_master_cfg #(.DATA_W(8), .HALF_PERIOD(2), .CPOL(m / 2),
                       .CPHA(m % 2), .LSB_FIRST((m < 2) ? 1 : 0))
         u (._i_clk(clk), ._i_rst(rst), .bus(ifm.master));
   end

   spi_master_cfg_if #(.DATA_W(1)) if6();
   assign if6._i_to_transmit = {req[6][16], req[6][0]};
   assign if6._i_miso = miso[6];
   assign obus[6] = 21'(if6.__output);
   spi_master_cfg #(.DATA_W(1), .HALF_PERIOD(1), .CPOL(1),
                    .CPHA(0), .LSB_FIRST(1))
      u6 (._i_clk(clk), ._i_rst(rst), .bus(if6.master));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // off: 4 sclk, 3 mosi, 2 cs_n, 1 busy, 0 rx_valid
   function automatic logic fld(int k, int off);
      return obus[k][DW[k] + off];
   endfunction

   function automatic logic [4:0] ctl(int k);
      return {fld(k, 4), fld(k, 3), fld(k, 2), fld(k, 1), fld(k, 0)};
   endfunction

   function automatic logic [15:0] mask(int k);
      return 16'((32'd1 << DW[k]) - 1);
   endfunction

   function automatic logic [15:0] rxd(int k);
      return obus[k][15:0] & mask(k);
   endfunction

   function automatic int posn(int k, int b);
      return (LSBF[k] != 0) ? b : DW[k] - 1 - b;
   endfunction

   function automatic logic [20:0] rst_vec(int k);
      logic [20:0] v;
      v = 21'(1) << (DW[k] + 2);
      if (CPL[k] != 0) v = v | (21'(1) << (DW[k] + 4));
      return v;
   endfunction

   // Called at a negedge. chain: request already pending and accepted
   // at the next edge. inject: present nxt mid-transfer and hold it.
   task automatic run_xfer(input int k, input logic [15:0] pay,
                           input logic [15:0] slv, input bit lpbk,
                           input bit chain, input bit inject,
                           input logic [15:0] nxt);
      int          tot;
      int          edges;
      int          b;
      bit          phb;
      logic        cpol;
      logic        lead;
      logic        prev;
      logic        o;
      logic [4:0]  c5;
      logic [4:0]  e;
      logic [15:0] exp_rx;
      tot  = 2 * HP[k] * DW[k];
      cpol = (CPL[k] != 0);
      lead = (CPH[k] != 0) ? !cpol : cpol;
      pay  = pay & mask(k);
      if (!chain) begin
         c5 = ctl(k);
         check($sformatf("idle%0d", k), {c5[4], c5[2:0]},
               {cpol, 3'b100});
         req[k] = {1'b1, pay};
      end
      @(posedge clk);
      @(negedge clk);
      req[k][16] = 1'b0;
      prev  = cpol;
      edges = 0;
      for (int c = 0; c < tot; c++) begin
         b   = c / (2 * HP[k]);
         phb = ((c / HP[k]) % 2) == 1;
         e   = {phb ? !lead : lead, pay[posn(k, b)], 3'b010};
         check($sformatf("shift%0d c%0d", k, c), ctl(k), e);
         o = fld(k, 4);
         if (o != prev) edges++;
         prev    = o;
         miso[k] = lpbk ? fld(k, 3) : slv[posn(k, b)];
         if (inject && c == tot / 2) req[k] = {1'b1, nxt};
         @(posedge clk);
         @(negedge clk);
      end
      o = fld(k, 4);
      if (o != prev) edges++;
      exp_rx = (lpbk ? pay : slv) & mask(k);
      check($sformatf("done%0d", k), ctl(k),
            {cpol, pay[posn(k, DW[k] - 1)], 3'b101});
      check($sformatf("rx_data%0d", k), rxd(k), exp_rx);
      check($sformatf("edges%0d", k), edges, 2 * DW[k]);
      if (!inject) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("rx_pulse%0d", k), fld(k, 0), 1'b0);
         check($sformatf("rx_hold%0d", k), rxd(k), exp_rx);
      end
   endtask

   initial begin
      logic [4:0] c5;
      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         req[k]  = '0;
         miso[k] = 1'b0;
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NI; k++)
         check($sformatf("reset%0d", k), obus[k], rst_vec(k));
      rst = 1'b0;
      repeat (2000) @(negedge clk);
      c5 = ctl(0);
      check("idle_long", {c5[4], c5[2:1]}, 3'b110);

      run_xfer(0, 16'h00B2, 16'($urandom), 0, 0, 0, '0);

      run_xfer(1, 16'hA5C3, '0, 1, 0, 0, '0);
      repeat (2)
         run_xfer(1, 16'($urandom), '0, 1, 0, 0, '0);

      for (int k = 2; k < 6; k++) begin
         run_xfer(k, 16'($urandom), 16'h003C, 0, 0, 0, '0);
         repeat (2)
            run_xfer(k, 16'($urandom), 16'($urandom), 0, 0, 0, '0);
      end

      run_xfer(2, 16'h0001, 16'($urandom), 0, 0, 1, 16'h00FF);
      run_xfer(2, 16'h00FF, 16'($urandom), 0, 1, 0, '0);

      run_xfer(6, 16'h1, 16'h1, 0, 0, 0, '0);
      run_xfer(6, 16'h0, 16'h1, 0, 0, 0, '0);
      run_xfer(6, 16'h1, 16'h0, 0, 0, 0, '0);

      // abort in the middle of bit 3 of a default-config transfer
      req[0] = {1'b1, 16'($urandom)};
      miso[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req[0][16] = 1'b0;
      repeat (3 * 1000 + 250) @(negedge clk);
      check("mid_busy", fld(0, 1), 1'b1);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < NI; k++)
         check($sformatf("rst_async%0d", k), obus[k], rst_vec(k));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("post_rst%0d", i), obus[0], rst_vec(0));
      end
      run_xfer(0, 16'h0055, 16'($urandom), 0, 0, 0, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
- Parametrised SPI master transceiver; successor to the fixed 8-bit, mode-3-idle, transmit-only SPI transmitter.
- Adds configurable word width, SCLK divider, CPOL/CPHA mode and bit order, plus a chip select and MISO receive with a received-word strobe.
- Sits between the core logic and an external SPI slave.
- Inputs use the Option-style packing: MSB is the valid bit. Outputs are one packed `__output` bus.

Parameters:
- DATA_W, 8: bits per transfer; must be >= 1.
- HALF_PERIOD, 500: `_i_clk` cycles per SCLK half-period; must be >= 1.
- CPOL, 1: SCLK idle level.
- CPHA, 0: 0 = sample on the leading edge, shift on the trailing edge; 1 = shift on the leading edge, sample on the trailing edge.
- LSB_FIRST, 1: 1 = bit 0 first; 0 = bit DATA_W-1 first.

Ports:
- `_i_clk`  input  1  clock, rising-edge.
- `_i_rst`  input  1  reset, asynchronous, active-high.
- `_i_to_transmit`  input  DATA_W+1  request word; bit DATA_W = valid, bits [DATA_W-1:0] = payload.
- `_i_miso`  input  1  serial data from the slave.
- `__output`  output  DATA_W+5  packed `{sclk, mosi, cs_n, busy, rx_valid, rx_data[DATA_W-1:0]}`, with sclk in the MSB.

Behaviour:
- Clock and reset: one clock domain; every output comes from a register. While `_i_rst`=1, immediately and independent of the clock:
  - sclk = CPOL
  - mosi = 0
  - cs_n = 1
  - busy = 0
  - rx_valid = 0
  - rx_data = 0
  - all internal counters and shift registers = 0
- Reset mid-transfer: the transfer is aborted and nothing is flagged.
- States: IDLE and SHIFT.
- IDLE:
  - Outputs: sclk = CPOL, cs_n = 1, busy = 0.
  - Accept on a rising edge where valid = 1 and busy = 0. After that edge: busy = 1, cs_n = 0, mosi = first bit, payload latched, bit index = 0, half-period counter = 0; go to SHIFT.
  - A valid request while busy = 1 is ignored. There is no queue; the bench must re-present it.
- SHIFT: each bit occupies 2*HALF_PERIOD cycles, split into phase A then phase B of HALF_PERIOD cycles each.
  - CPHA=0:
    - Phase A: sclk = CPOL.
    - Phase B: sclk = !CPOL; `_i_miso` is sampled at the rising edge that sets sclk to !CPOL.
    - At the end of phase B, sclk returns to CPOL and mosi moves to the next bit on the same edge.
  - CPHA=1:
    - Phase A: sclk = !CPOL; mosi moves to this bit on the edge that enters phase A.
    - Phase B: sclk = CPOL; `_i_miso` is sampled at the edge that enters phase B.
  - Bit order follows LSB_FIRST for both mosi and rx assembly. rx_data[i] receives the i-th transmitted bit position.
- Completion:
  - After DATA_W bits, busy stays 1 for exactly 2*HALF_PERIOD*DATA_W cycles.
  - On the next edge: busy = 0, cs_n = 1, sclk = CPOL, mosi holds its last value, rx_data = assembled word, rx_valid = 1 for exactly one cycle.
  - rx_data holds until the next completion or reset.
- Back-to-back: a request held valid through completion is accepted on the edge after busy falls. cs_n therefore deasserts for at least one cycle between words.
- The payload is latched at accept. Changes to `_i_to_transmit` during SHIFT have no effect.
- HALF_PERIOD=1: SCLK toggles every cycle; the same rules hold.
- The half-period counter wraps from HALF_PERIOD-1 to 0, and its width is the ceiling of log2(HALF_PERIOD) with a minimum of 1.

Test Plan:
- Defaults: reset 4 cycles, valid=0 for 2000 cycles -> busy=0, sclk=1, cs_n=1. Then send 0x0B2 (9-bit, payload 0xB2) -> 2 negedges later cs_n=0, mosi=0 (bit0). For each bit i: sclk=1 and mosi=bit i at the start of the bit, sclk=0 after 500 cycles. After 8000 cycles: busy=0, sclk=1.
- Loopback (miso=mosi), DATA_W=16, HALF_PERIOD=4, CPHA=0, LSB_FIRST=0, payload 0xA5C3 -> busy high 128 cycles, rx_valid single-cycle pulse, rx_data=0xA5C3, first mosi bit=1.
- All four CPOL/CPHA combos, HALF_PERIOD=2, slave model returning 0x3C -> rx_data=0x3C in each mode, SCLK idle level = CPOL, edge count = 2*DATA_W.
- Request valid while busy with payload 0xFF during a 0x01 transfer -> ignored; the held request starts 1 cycle after busy falls, and cs_n is high for exactly 1 cycle between words.
- Assert `_i_rst` asynchronously mid-bit 3 -> outputs return to reset values without waiting for a clock edge, and there is no rx_valid. A new 0x55 request after release completes correctly.
- HALF_PERIOD=1, DATA_W=1, payload 1, miso=1 -> busy high 2 cycles, rx_data=1, rx_valid pulses once.
